// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard stall unit
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1
  } state_e;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;

  // Register zero never carries a real dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] dest,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt,
                                     input logic use_rs,
                                     input logic use_rt);
    return (dest != '0) && ((use_rs && (rs == dest)) || (use_rt && (rt == dest)));
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// rtl/sat_counter16.sv - enabled up-counter that sticks at its maximum value
module sat_counter16
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != CNT_SAT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - pipeline interlock: load-use and branch-operand stalls,
// taken-branch IF/ID flush, and stall/flush statistics.
module hazard_stall_unit
  import hazard_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic [REG_W-1:0] RsFieldID,
  input  logic [REG_W-1:0] RtFieldID,
  input  logic             UsesRsID,
  input  logic             UsesRtID,
  input  logic             BranchID,
  input  logic             BranchTakenID,
  input  logic             MemReadEX,
  input  logic             RegWriteEX,
  input  logic             RegDstEX,
  input  logic [REG_W-1:0] RDFieldEX,
  input  logic [REG_W-1:0] RTFieldEX,
  input  logic             MemReadMEM,
  input  logic             RegWriteMEM,
  input  logic [REG_W-1:0] DestRegMEM,
  output logic             PCWriteOut,
  output logic             IFIDWriteOut,
  output logic             IDEXBubbleOut,
  output logic             IFIDFlushOut,
  output logic [1:0]       StateOut,
  output logic [CNT_W-1:0] StallCycleCntOut,
  output logic [CNT_W-1:0] FlushCntOut
);

  state_e           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [REG_W-1:0] dest_ex;
  logic             match_ex;
  logic             match_mem;
  logic [1:0]       need_n;
  logic             stall;
  logic             flush;

  assign dest_ex   = RegDstEX ? RDFieldEX : RTFieldEX;
  assign match_ex  = reg_match(dest_ex, RsFieldID, RtFieldID, UsesRsID, UsesRtID);
  assign match_mem = reg_match(DestRegMEM, RsFieldID, RtFieldID, UsesRsID, UsesRtID);

  // Conditions are ordered so the first hit is already the maximum stall count.
  always_comb begin
    need_n = 2'd0;
    if (MemReadEX && RegWriteEX && match_ex) begin
      need_n = BranchID ? 2'd2 : 2'd1;
    end else if (BranchID && RegWriteEX && match_ex) begin
      need_n = 2'd1;
    end else if (BranchID && MemReadMEM && RegWriteMEM && match_mem) begin
      need_n = 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall   = 1'b0;
    flush   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (need_n != 2'd0) begin
          stall = 1'b1;
          if (need_n == 2'd2) begin
            state_d = ST_STALL;
            rem_d   = 2'd1;
          end
        end else begin
          flush = BranchID && BranchTakenID;
        end
      end
      ST_STALL: begin
        stall = 1'b1;
        rem_d = rem_q - 2'd1;
        if (rem_q <= 2'd1) begin
          state_d = ST_RUN;
          rem_d   = 2'd0;
        end
      end
      default: begin
        state_d = ST_RUN;
        rem_d   = 2'd0;
      end
    endcase
    if (!Rst) begin
      stall = 1'b1;
      flush = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= ST_RUN;
      rem_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  assign PCWriteOut    = ~stall;
  assign IFIDWriteOut  = ~stall;
  assign IDEXBubbleOut = stall;
  assign IFIDFlushOut  = flush;
  assign StateOut      = state_q;

  sat_counter16 u_stall_cnt (
    .clk   (Clk),
    .clr_n (Rst),
    .en    (stall && Rst),
    .count (StallCycleCntOut)
  );

  sat_counter16 u_flush_cnt (
    .clk   (Clk),
    .clr_n (Rst),
    .en    (flush && Rst),
    .count (FlushCntOut)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - directed and random checks against a bubble-count model
module tb_hazard_stall_unit;

  logic        clk;
  logic        rst;
  logic [4:0]  rs_id, rt_id;
  logic        uses_rs, uses_rt, br_id, br_taken;
  logic        memrd_ex, regw_ex, regdst_ex;
  logic [4:0]  rd_ex, rt_ex;
  logic        memrd_mem, regw_mem;
  logic [4:0]  dest_mem;
  logic        pc_wr, ifid_wr, bubble, flush;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  int n_checks;
  int n_pass;
  int bubbles_left;
  int m_stall_cnt;
  int m_flush_cnt;

  hazard_stall_unit dut (
    .Clk              (clk),
    .Rst              (rst),
    .RsFieldID        (rs_id),
    .RtFieldID        (rt_id),
    .UsesRsID         (uses_rs),
    .UsesRtID         (uses_rt),
    .BranchID         (br_id),
    .BranchTakenID    (br_taken),
    .MemReadEX        (memrd_ex),
    .RegWriteEX       (regw_ex),
    .RegDstEX         (regdst_ex),
    .RDFieldEX        (rd_ex),
    .RTFieldEX        (rt_ex),
    .MemReadMEM       (memrd_mem),
    .RegWriteMEM      (regw_mem),
    .DestRegMEM       (dest_mem),
    .PCWriteOut       (pc_wr),
    .IFIDWriteOut     (ifid_wr),
    .IDEXBubbleOut    (bubble),
    .IFIDFlushOut     (flush),
    .StateOut         (state),
    .StallCycleCntOut (stall_cnt),
    .FlushCntOut      (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic bit reads(input logic [4:0] d);
    if (d == 5'd0) return 1'b0;
    return (uses_rs && rs_id == d) || (uses_rt && rt_id == d);
  endfunction

  function automatic int needed_bubbles();
    int n;
    logic [4:0] d;
    d = regdst_ex ? rd_ex : rt_ex;
    n = 0;
    if (memrd_ex && regw_ex && reads(d)) n = br_id ? 2 : 1;
    if (br_id && regw_ex && !memrd_ex && reads(d) && n < 1) n = 1;
    if (br_id && memrd_mem && regw_mem && reads(dest_mem) && n < 1) n = 1;
    return n;
  endfunction

  task automatic clear_inputs();
    rs_id = 0; rt_id = 0; uses_rs = 0; uses_rt = 0; br_id = 0; br_taken = 0;
    memrd_ex = 0; regw_ex = 0; regdst_ex = 0; rd_ex = 0; rt_ex = 0;
    memrd_mem = 0; regw_mem = 0; dest_mem = 0;
  endtask

  // Called just after the negedge with inputs in place; returns at the next negedge.
  task automatic cycle();
    bit e_stall, e_flush;
    int e_state, n;
    #2;
    e_state = (bubbles_left > 0) ? 1 : 0;
    e_flush = 1'b0;
    if (!rst) begin
      e_stall = 1'b1;
    end else if (bubbles_left > 0) begin
      e_stall = 1'b1;
    end else begin
      n = needed_bubbles();
      e_stall = (n > 0);
      if (n == 0) e_flush = br_id && br_taken;
    end
    check_eq("pc_write", pc_wr, !e_stall);
    check_eq("ifid_write", ifid_wr, !e_stall);
    check_eq("idex_bubble", bubble, e_stall);
    check_eq("ifid_flush", flush, e_flush);
    check_eq("state", state, e_state);
    check_eq("stall_cnt", stall_cnt, m_stall_cnt);
    check_eq("flush_cnt", flush_cnt, m_flush_cnt);
    if (!rst) begin
      bubbles_left = 0;
      m_stall_cnt  = 0;
      m_flush_cnt  = 0;
    end else begin
      if (bubbles_left > 0) bubbles_left--;
      else if (e_stall) bubbles_left = needed_bubbles() - 1;
      if (e_stall && m_stall_cnt < 65535) m_stall_cnt++;
      if (e_flush && m_flush_cnt < 65535) m_flush_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
  endtask

  task automatic set_load_use(input logic br);
    clear_inputs();
    memrd_ex = 1; regw_ex = 1; regdst_ex = 0; rt_ex = 5'd8;
    rs_id = 5'd8; uses_rs = 1; br_id = br;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    bubbles_left = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // load-use, non-branch consumer: one bubble, FSM stays in RUN
    do_reset();
    set_load_use(1'b0);
    cycle();
    clear_inputs();
    #1;
    check_eq("lu_bubble_done", bubble, 0);
    check_eq("lu_state", state, 0);
    check_eq("lu_stall_cnt", stall_cnt, 1);
    cycle();

    // load feeding a branch: two bubbles, second one in STALL
    do_reset();
    set_load_use(1'b1);
    cycle();
    #1;
    check_eq("lb_state2", state, 1);
    check_eq("lb_bubble2", bubble, 1);
    cycle();
    clear_inputs();
    #1;
    check_eq("lb_state_run", state, 0);
    check_eq("lb_stall_cnt", stall_cnt, 2);
    check_eq("lb_pc_write", pc_wr, 1);
    cycle();

    // ALU result feeding a branch, then taken branch flushes
    do_reset();
    clear_inputs();
    regw_ex = 1; regdst_ex = 1; rd_ex = 5'd5; rt_id = 5'd5; uses_rt = 1; br_id = 1;
    cycle();
    regw_ex = 0; br_taken = 1;
    #1;
    check_eq("ab_flush", flush, 1);
    cycle();
    clear_inputs();
    #1;
    check_eq("ab_flush_cnt", flush_cnt, 1);
    check_eq("ab_stall_cnt", stall_cnt, 1);
    cycle();

    // register zero is never a hazard
    do_reset();
    clear_inputs();
    memrd_ex = 1; regw_ex = 1; uses_rs = 1;
    #1;
    check_eq("r0_pc_write", pc_wr, 1);
    cycle();

    // reset in the middle of a two-cycle stall aborts it
    do_reset();
    set_load_use(1'b1);
    cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    clear_inputs();
    #1;
    check_eq("rs_state", state, 0);
    check_eq("rs_stall_cnt", stall_cnt, 0);
    check_eq("rs_flush_cnt", flush_cnt, 0);
    check_eq("rs_pc_write", pc_wr, 1);
    cycle();

    // saturation of the stall counter
    do_reset();
    set_load_use(1'b0);
    for (int i = 0; i < 65540; i++) cycle();
    clear_inputs();
    #1;
    check_eq("sat_stall_cnt", stall_cnt, 32'h0000_FFFF);
    cycle();

    // random traffic over a small register range so matches are frequent
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 39) != 0);
      rs_id     = 5'($urandom_range(0, 3));
      rt_id     = 5'($urandom_range(0, 3));
      uses_rs   = 1'($urandom);
      uses_rt   = 1'($urandom);
      br_id     = 1'($urandom);
      br_taken  = 1'($urandom);
      memrd_ex  = 1'($urandom);
      regw_ex   = 1'($urandom);
      regdst_ex = 1'($urandom);
      rd_ex     = 5'($urandom_range(0, 3));
      rt_ex     = 5'($urandom_range(0, 3));
      memrd_mem = 1'($urandom);
      regw_mem  = 1'($urandom);
      dest_mem  = 5'($urandom_range(0, 3));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
